// File: rtl/dmmu_tlb_sram_ctrl.sv
// DMMU TLB SRAM sequencer: arbitrates lookup/SPR access to one macro.
// Define TLB_FLUSH_EN to build the invalidate-all sweep.
module dmmu_tlb_sram_ctrl #(
  parameter int AW = 6,
  parameter int DW = 24,
  parameter logic [DW-1:0] FLUSH_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lu_req,
  input  logic [AW-1:0] lu_addr,
  output logic          lu_ack,
  output logic [DW-1:0] lu_rdata,
  input  logic          spr_req,
  input  logic          spr_we,
  input  logic [AW-1:0] spr_addr,
  input  logic [DW-1:0] spr_wdata,
  output logic          spr_ack,
  output logic [DW-1:0] spr_rdata,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_i,
  input  logic [DW-1:0] sram_o,
  output logic          sram_ce,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic          sram_csb
);

`ifdef TLB_FLUSH_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, F_SETUP, F_STROBE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE
  } state_t;
`endif

  state_t        state_q;
  logic          rr_spr_q;
  logic          win_spr_q;
  logic          we_q;
  logic          lu_ack_q;
  logic          spr_ack_q;
  logic [DW-1:0] lu_rdata_q;
  logic [DW-1:0] spr_rdata_q;
  logic [AW-1:0] sram_a_q;
  logic [DW-1:0] sram_i_q;
  logic          sram_ce_q;
  logic          sram_web_q;
  logic          sram_oeb_q;
  logic          sram_csb_q;

  logic lu_v;
  logic spr_v;
  logic gnt_lu;
  logic gnt_spr;
  logic spr_wr;

  // A requester is deaf during its own ack cycle
  assign lu_v    = lu_req & ~lu_ack_q;
  assign spr_v   = spr_req & ~spr_ack_q;
  assign gnt_spr = spr_v & (~lu_v | ~rr_spr_q);
  assign gnt_lu  = lu_v & ~gnt_spr;
  assign spr_wr  = gnt_spr & spr_we;

`ifdef TLB_FLUSH_EN
  logic flush_pend_q;
  logic flush_busy_q;
  assign flush_busy = flush_busy_q;
`else
  logic unused_flush;
  assign unused_flush = flush_req ^ (|FLUSH_VAL);
  assign flush_busy   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_spr_q    <= 1'b1;
      win_spr_q   <= 1'b0;
      we_q        <= 1'b0;
      lu_ack_q    <= 1'b0;
      spr_ack_q   <= 1'b0;
      lu_rdata_q  <= '0;
      spr_rdata_q <= '0;
      sram_a_q    <= '0;
      sram_i_q    <= '0;
      sram_ce_q   <= 1'b0;
      sram_web_q  <= 1'b1;
      sram_oeb_q  <= 1'b1;
      sram_csb_q  <= 1'b1;
`ifdef TLB_FLUSH_EN
      flush_pend_q <= 1'b0;
      flush_busy_q <= 1'b0;
`endif
    end else begin
      lu_ack_q  <= 1'b0;
      spr_ack_q <= 1'b0;
`ifdef TLB_FLUSH_EN
      if (flush_req && !flush_busy_q) begin
        flush_pend_q <= 1'b1;
        flush_busy_q <= 1'b1;
      end
`endif
      unique case (state_q)
        IDLE: begin
`ifdef TLB_FLUSH_EN
          if (flush_pend_q) begin
            flush_pend_q <= 1'b0;
            state_q      <= F_SETUP;
            sram_a_q     <= '0;
            sram_i_q     <= FLUSH_VAL;
            sram_csb_q   <= 1'b0;
            sram_web_q   <= 1'b0;
            sram_oeb_q   <= 1'b1;
          end else
`endif
          if (gnt_lu || gnt_spr) begin
            state_q    <= SETUP;
            win_spr_q  <= gnt_spr;
            rr_spr_q   <= gnt_spr;
            we_q       <= spr_wr;
            sram_a_q   <= gnt_spr ? spr_addr : lu_addr;
            sram_i_q   <= spr_wr ? spr_wdata : sram_i_q;
            sram_csb_q <= 1'b0;
            sram_web_q <= ~spr_wr;
            sram_oeb_q <= spr_wr;
          end
        end
        SETUP: begin
          sram_ce_q <= 1'b1;
          state_q   <= STROBE;
        end
        STROBE: begin
          sram_ce_q  <= 1'b0;
          sram_csb_q <= 1'b1;
          sram_web_q <= 1'b1;
          sram_oeb_q <= 1'b1;
          state_q    <= IDLE;
          if (win_spr_q) begin
            spr_ack_q <= 1'b1;
            if (!we_q) spr_rdata_q <= sram_o;
          end else begin
            lu_ack_q   <= 1'b1;
            lu_rdata_q <= sram_o;
          end
        end
`ifdef TLB_FLUSH_EN
        F_SETUP: begin
          sram_ce_q <= 1'b1;
          state_q   <= F_STROBE;
        end
        F_STROBE: begin
          sram_ce_q <= 1'b0;
          if (sram_a_q == {AW{1'b1}}) begin
            sram_csb_q   <= 1'b1;
            sram_web_q   <= 1'b1;
            flush_busy_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            sram_a_q <= sram_a_q + 1'b1;
            state_q  <= F_SETUP;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lu_ack    = lu_ack_q;
  assign spr_ack   = spr_ack_q;
  assign lu_rdata  = lu_rdata_q;
  assign spr_rdata = spr_rdata_q;
  assign sram_a    = sram_a_q;
  assign sram_i    = sram_i_q;
  assign sram_ce   = sram_ce_q;
  assign sram_web  = sram_web_q;
  assign sram_oeb  = sram_oeb_q;
  assign sram_csb  = sram_csb_q;

endmodule
